// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Holds the reset PC, the NOP encoding, the fetch FSM states and the debug view.
package fetch_pkg;

  localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;
  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Sized for the largest legal DEPTH (16), so counters fit in 5 bits.
  typedef struct packed {
    fetch_state_e state;
    logic [4:0]   outstanding;
    logic [4:0]   stale;
  } fetch_dbg_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a flush that empties it in one cycle.
// Flush wins over push and pop issued in the same cycle.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues credit-limited requests, tags in-order responses with
// their PC, queues them for decode, and drains stale responses after a redirect.
module fetch_queue import fetch_pkg::*; #(
  parameter logic [31:0] BASEADDR = BASEADDR_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req_valid,
  output logic [31:0]             imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_rsp_valid,
  input  logic [INSN_W-1:0]       imem_rsp_data,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    dec_valid,
  output logic [31:0]             dec_pc,
  output logic [INSN_W-1:0]       dec_insn,
  input  logic                    dec_ready,
  output logic [$clog2(DEPTH):0]  count,
  output fetch_dbg_t              dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and imem responses carry no ready (always accepted).

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);
  localparam logic [0:0] S_FETCH = FETCH;
  localparam logic [0:0] S_DRAIN = DRAIN;

  logic [0:0]              state;
  logic [31:0]             fetch_pc;
  logic [31:0]             rsp_pc;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           outstanding_nxt;
  logic [CW-1:0]           stale;
  logic                    credit_ok;
  logic                    req_fire;
  logic                    rsp_take;
  logic                    push;
  logic                    pop;
  logic [31+INSN_W:0]      head;

  // Credit uses registered occupancy only; a pop this cycle frees space next cycle.
  assign credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_X;
  assign imem_req_valid  = reset && (state == S_FETCH) && credit_ok;
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp_take        = imem_rsp_valid && (outstanding != '0);
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);

  assign push = rsp_take && (state == S_FETCH) && !redirect_valid;
  assign pop  = dec_valid && dec_ready && !redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      fetch_pc    <= BASEADDR;
      rsp_pc      <= BASEADDR;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        stale    <= outstanding_nxt;
        state    <= (outstanding_nxt != '0) ? S_DRAIN : S_FETCH;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     rsp_pc   <= rsp_pc + 32'd4;
        if ((state == S_DRAIN) && rsp_take) begin
          stale <= stale - CW'(1);
          if (stale == CW'(1)) state <= S_FETCH;
        end
      end
    end
  end

  fetch_fifo #(
    .W     (32 + INSN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({rsp_pc, imem_rsp_data}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign dec_valid = (count != '0);
  assign dec_pc    = dec_valid ? head[31+INSN_W:INSN_W] : 32'h0;
  assign dec_insn  = dec_valid ? head[INSN_W-1:0] : NOP;

  assign dbg.state       = fetch_state_e'(state);
  assign dbg.outstanding = 5'(outstanding);
  assign dbg.stale       = 5'(stale);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory responder with 1-cycle latency,
// hand-computed expectations checked by immediate assertions.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_insn;
  logic        dec_ready = 1'b0;
  logic [2:0]  count;
  fetch_dbg_t  dbg;

  int passed = 0;
  int total  = 0;
  logic        rsp_hold = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_pc_q[$];
  logic [31:0] got_insn_q[$];

  // clock / reset
  always #5 clk = ~clk;

  fetch_queue #(.BASEADDR(32'h0100_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .dec_insn       (dec_insn),
    .dec_ready      (dec_ready),
    .count          (count),
    .dbg            (dbg)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0100_0000: return 32'hfd01_0113;
      32'h0100_0004: return 32'h0211_2623;
      32'h0100_0008: return 32'h0001_2e23;
      default:       return ~addr;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; models memory accepting requests and answering one cycle later.
  task automatic tick();
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      pend_q.push_back(imem_req_addr);
      acc_q.push_back(imem_req_addr);
    end
    @(posedge clk);
    #1;
    if (reset && !rsp_hold && pend_q.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    rsp_hold       = 1'b0;
    pend_q.delete();
    acc_q.delete();
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // ---- reset state ----
    tick();
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0100_0000);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_insn", dec_insn, 32'h0000_0013);
    check("rst_count", 32'(count), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(FETCH));
    reset = 1'b1;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0100_0000);

    // ---- first fetch ----
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("first_rsp_not_yet", 32'(dec_valid), 32'd0);
    tick();
    check("first_dec_valid", 32'(dec_valid), 32'd1);
    check("first_dec_pc", dec_pc, 32'h0100_0000);
    check("first_dec_insn", dec_insn, 32'hfd01_0113);
    check("first_count", 32'(count), 32'd1);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("pop_empty_valid", 32'(dec_valid), 32'd0);
    check("pop_empty_pc", dec_pc, 32'h0);
    check("pop_empty_insn", dec_insn, 32'h0000_0013);

    // ---- streaming ----
    do_reset();
    exp_q = '{32'h0100_0000, 32'h0100_0004, 32'h0100_0008, 32'h0100_000C};
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dec_valid === 1'b1) begin
        got_pc_q.push_back(dec_pc);
        got_insn_q.push_back(dec_insn);
      end
    end
    check("stream_entries", got_pc_q.size(), 32'd11);
    for (int i = 0; i < 4; i++) check($sformatf("stream_pc%0d", i), got_pc_q[i], exp_q[i]);
    check("stream_insn0", got_insn_q[0], 32'hfd01_0113);
    check("stream_insn1", got_insn_q[1], 32'h0211_2623);
    check("stream_insn2", got_insn_q[2], 32'h0001_2e23);
    check("stream_count", 32'(count), 32'd1);

    // ---- reset mid-operation ----
    reset = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_dec_valid", 32'(dec_valid), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_outstanding", 32'(dbg.outstanding), 32'd0);
    do_reset();
    check("midrst_restart_addr", imem_req_addr, 32'h0100_0000);
    tick();
    check("midrst_no_push", 32'(count), 32'd0);

    // ---- backpressure ----
    do_reset();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("bp_count", 32'(count), 32'd4);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_outstanding", 32'(dbg.outstanding), 32'd0);
    check("bp_num_accepted", acc_q.size(), 32'd4);
    check("bp_last_addr", acc_q[acc_q.size()-1], 32'h0100_000C);
    check("bp_head_pc", dec_pc, 32'h0100_0000);
    imem_req_ready = 1'b0;
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("bp_pop_count", 32'(count), 32'd3);
    check("bp_resume_valid", 32'(imem_req_valid), 32'd1);
    check("bp_resume_addr", imem_req_addr, 32'h0100_0010);

    // ---- redirect with two outstanding ----
    do_reset();
    rsp_hold = 1'b1;
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    check("rd_outstanding", 32'(dbg.outstanding), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0102;
    tick();
    redirect_valid = 1'b0;
    check("rd_state_drain", 32'(dbg.state), 32'(DRAIN));
    check("rd_stale", 32'(dbg.stale), 32'd2);
    check("rd_req_valid", 32'(imem_req_valid), 32'd0);
    check("rd_addr", imem_req_addr, 32'h0100_0100);
    rsp_hold = 1'b0;
    tick();
    tick();
    check("rd_stale_one", 32'(dbg.stale), 32'd1);
    check("rd_drop_one", 32'(count), 32'd0);
    tick();
    check("rd_state_fetch", 32'(dbg.state), 32'(FETCH));
    check("rd_drop_both", 32'(count), 32'd0);
    check("rd_next_valid", 32'(imem_req_valid), 32'd1);
    check("rd_next_addr", imem_req_addr, 32'h0100_0100);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("rd_dec_valid", 32'(dec_valid), 32'd1);
    check("rd_dec_pc", dec_pc, 32'h0100_0100);
    check("rd_dec_insn", dec_insn, 32'hfeff_feff);

    // ---- redirect with simultaneous response and pop ----
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    check("co_count_before", 32'(count), 32'd1);
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0200;
    tick();
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    check("co_count", 32'(count), 32'd0);
    check("co_dec_valid", 32'(dec_valid), 32'd0);
    check("co_state", 32'(dbg.state), 32'(FETCH));
    check("co_outstanding", 32'(dbg.outstanding), 32'd0);
    check("co_addr", imem_req_addr, 32'h0100_0200);
    tick();
    check("co_not_enqueued", 32'(count), 32'd0);

    // ---- PC wrap ----
    redirect_valid = 1'b1;
    redirect_pc = 32'hffff_fffc;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_req_addr, 32'hffff_fffc);
    imem_req_ready = 1'b1;
    tick();
    check("wrap_addr1", imem_req_addr, 32'h0000_0000);
    check("wrap_valid1", 32'(imem_req_valid), 32'd1);
    tick();
    imem_req_ready = 1'b0;
    check("wrap_acc0", acc_q[acc_q.size()-2], 32'hffff_fffc);
    check("wrap_acc1", acc_q[acc_q.size()-1], 32'h0000_0000);
    check("wrap_dec_pc", dec_pc, 32'hffff_fffc);
    check("wrap_dec_insn", dec_insn, 32'h0000_0003);
    tick();
    check("wrap_count", 32'(count), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter BASEADDR, default 32'h01000000, meaning the PC fetched first after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; legal values are powers of 2 from 2 to 16.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  meaning a fetch request is presented.
REQ-006 SHALL have port imem_req_addr  output  32  meaning the fetch address; bits [1:0] are always 0.
REQ-007 SHALL have port imem_req_ready  input  1  meaning memory accepts the request this cycle.
REQ-008 SHALL have port imem_rsp_valid  input  1  meaning instruction data is returned, in request order, one or more cycles after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  meaning the returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  meaning a PC redirect (branch/jump) is requested.
REQ-011 SHALL have port redirect_pc  input  32  meaning the redirect target.
REQ-012 SHALL have port dec_valid  output  1  meaning the queue head is valid for decode.
REQ-013 SHALL have port dec_pc  output  32  meaning the PC of the head instruction.
REQ-014 SHALL have port dec_insn  output  32  meaning the head instruction word.
REQ-015 SHALL have port dec_ready  input  1  meaning decode consumes the head this cycle.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  meaning current queue occupancy.

Function
REQ-017 SHALL hold fetch_pc; a request is accepted when imem_req_valid and imem_req_ready are both 1, and fetch_pc then advances by 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-018 SHALL assert imem_req_valid only in state FETCH, and only when registered count + outstanding < DEPTH; a same-cycle pop does not bypass into this credit check.
REQ-019 SHALL track outstanding, the number of accepted requests not yet responded to, which never exceeds DEPTH.
REQ-020 SHALL tag each non-stale response with rsp_pc, which starts at the fetch PC and increments by 4 per response, and SHALL push {rsp_pc, imem_rsp_data} into the queue; the entry is visible on dec_* the next cycle (latency 1).
REQ-021 SHALL pop the head when dec_valid and dec_ready are both 1; dec_valid equals (count != 0).
REQ-022 SHALL drive dec_pc = 0 and dec_insn = 32'h00000013 (NOP) while the queue is empty.
REQ-023 SHALL, on the same cycle as a simultaneous push and pop, leave count unchanged and preserve ordering.
REQ-024 SHALL implement FSM states FETCH and DRAIN.
REQ-025 SHALL, on redirect_valid, flush the queue (count = 0), set fetch_pc and rsp_pc to {redirect_pc[31:2], 2'b00}, and set stale to the post-edge outstanding count, including a request accepted in that same cycle.
REQ-026 SHALL go to DRAIN if stale > 0 after the redirect, otherwise to FETCH.
REQ-027 SHALL, in DRAIN, discard every response, decrement stale per response, and return to FETCH on the edge where stale reaches 0.
REQ-028 SHALL give redirect priority: a response arriving in the redirect cycle is treated as stale and discarded, and a dec handshake in the redirect cycle has no additional effect.
REQ-029 SHALL, on a redirect while in DRAIN, update the PCs, recompute stale per REQ-025, and remain in DRAIN.

Reset
REQ-030 SHALL, while reset = 0, force: state FETCH, fetch_pc = rsp_pc = BASEADDR, count = outstanding = stale = 0, imem_req_valid = 0, imem_req_addr = BASEADDR, dec_valid = 0, dec_pc = 0, dec_insn = NOP.
REQ-031 SHALL, when reset is asserted mid-operation, drop all outstanding and queued instructions with no further pushes.
REQ-032 SHALL present imem_req_valid = 1 with imem_req_addr = BASEADDR in the first cycle after reset deassertion.

Structure
REQ-033 SHALL take BASEADDR default, the NOP constant, INSN_W = 32 and the fetch_state_e enum {FETCH, DRAIN} from the shared package fetch_pkg.
REQ-034 SHALL instantiate one sub-module, fetch_fifo: a parameterised synchronous FIFO of width 64 and depth DEPTH with a flush input.

Verification
REQ-035 SHALL test reset: after release, the first accepted request has addr 01000000 and response fd010113 -> dec_valid=1, dec_pc=01000000, dec_insn=fd010113 one cycle later.
REQ-036 SHALL test streaming: ready=1, 1-cycle latency, memory {fd010113, 02112623, 00012e23}, dec_ready=1 -> dec_pc sequence 01000000, 01000004, 01000008 in order.
REQ-037 SHALL test backpressure with DEPTH=4 and dec_ready=0 -> count saturates at 4, imem_req_valid=0 with outstanding=0, and no request beyond addr 0100000C.
REQ-038 SHALL test redirect to 01000102 with 2 outstanding -> DRAIN; both stale responses are dropped; the next request addr is 01000100; dec_pc of the next entry is 01000100.
REQ-039 SHALL test a redirect coinciding with a response and a dec pop -> count=0 next cycle; the response is not enqueued.
REQ-040 SHALL test wrap: redirect to FFFFFFFC -> consecutive request addrs FFFFFFFC, 00000000.
